// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy, threshold flags and sticky error flags.
// Define SYNC_FIFO_PARAM_FWFT_EN for first-word-fall-through reads; the default is registered reads.
module sync_fifo_param #(
    parameter  int DWIDTH = 13,
    parameter  int DEPTH  = 16,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              reset_fifo,
    input  logic              fifo_push,
    input  logic              fifo_pop,
    input  logic [DWIDTH-1:0] fifo_din,
    input  logic [AWIDTH:0]   data_thresh,
    input  logic [AWIDTH:0]   space_thresh,
    input  logic              err_clr,
    output logic [DWIDTH-1:0] fifo_out,
    output logic [AWIDTH:0]   fifo_count,
    output logic              data_avail,
    output logic              almost_full,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              data_avail_q, almost_full_q;
    logic              push_ok, pop_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign push_ok    = fifo_push & ~fifo_full & ~reset_fifo;
    assign pop_ok     = fifo_pop & ~fifo_empty & ~reset_fifo;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (reset_fifo) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AWIDTH'(1);
            count_d = count_q + (AWIDTH + 1)'(push_ok) - (AWIDTH + 1)'(pop_ok);
            // A new error in the same cycle as err_clr must not be lost.
            if (fifo_push & fifo_full)  ovf_d = 1'b1;
            else if (err_clr)           ovf_d = 1'b0;
            if (fifo_pop & fifo_empty)  unf_d = 1'b1;
            else if (err_clr)           unf_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            data_avail_q  <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            data_avail_q  <= (count_q >= data_thresh);
            almost_full_q <= ((DEPTH_C - count_q) <= space_thresh);
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define which words are valid.
    always_ff @(posedge sys_clk) begin
        if (push_ok) mem[wr_ptr_q] <= fifo_din;
    end

`ifdef SYNC_FIFO_PARAM_FWFT_EN
    assign fifo_out = mem[rd_ptr_q];
`else
    logic [DWIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (reset_fifo)  out_d = '0;
        else if (pop_ok) out_d = mem[rd_ptr_q];
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) out_q <= '0;
        else           out_q <= out_d;
    end

    assign fifo_out = out_q;
`endif

    assign fifo_count  = count_q;
    assign data_avail  = data_avail_q;
    assign almost_full = almost_full_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for CPU-side peripheral buffering, such as UART RX/TX queues, with configurable width and depth. It adds programmable data-available and almost-full thresholds, an occupancy output, and sticky overflow/underflow error flags. The block sits between a byte-stream engine and the CPU register interface, all in the `sys_clk` domain. An optional first-word-fall-through read mode is available at compile time.

## Interface
- `DWIDTH`, 13, data width in bits (≥1).
- `DEPTH`, 16, number of entries; must be a power of two and ≥2. Derived `AWIDTH = $clog2(DEPTH)`.

Ports:
- `sys_clk`  in  1  system clock; every flop is rising-edge triggered.
- `sys_rstn`  in  1  reset, asynchronous assert, active-low.
- `reset_fifo`  in  1  synchronous CPU-controlled clear.
- `fifo_push`  in  1  write request.
- `fifo_pop`  in  1  read request.
- `fifo_din`  in  `DWIDTH`  write data.
- `data_thresh`  in  `AWIDTH+1`  data-available level.
- `space_thresh`  in  `AWIDTH+1`  almost-full free-space level.
- `err_clr`  in  1  clears the sticky error flags.
- `fifo_out`  out  `DWIDTH`  read data.
- `fifo_count`  out  `AWIDTH+1`  current occupancy, 0..`DEPTH`.
- `data_avail`  out  1  registered flag: `fifo_count >= data_thresh`.
- `almost_full`  out  1  registered flag: `DEPTH - fifo_count <= space_thresh`.
- `fifo_empty`  out  1  `fifo_count == 0`.
- `fifo_full`  out  1  `fifo_count == DEPTH`.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation
- **Storage:** `DEPTH` x `DWIDTH` distributed RAM.
  - Write pointer and read pointer are `AWIDTH` bits wide and wrap naturally from `DEPTH-1` to 0.
  - The RAM itself is never reset.
- **Accept rules:**
  - `push_ok = fifo_push & ~fifo_full`.
  - `pop_ok = fifo_pop & ~fifo_empty`.
  - Both rules are evaluated on the pre-edge count.
- **Count update:** `fifo_count` += `push_ok` − `pop_ok`. On an accepted push the write pointer increments and the RAM is written; on an accepted pop the read pointer increments.
- **Simultaneous push and pop:**
  - Full: the pop is accepted and the push is rejected; `overflow` sets and the count drops by 1.
  - Empty: the push is accepted and the pop is rejected; `underflow` sets and the count rises by 1.
  - Otherwise: both are accepted and the count is unchanged.
- **Standard read mode:** `fifo_out` is a register loaded with `mem[rd_ptr]` on an accepted pop, otherwise it holds its value.
- **Status flags:**
  - `fifo_empty` and `fifo_full` decode combinationally from the registered `fifo_count`.
  - `data_avail` and `almost_full` are registered from the pre-edge count, so they lag `fifo_count` by one cycle.
  - Thresholds are compared unsigned. A `data_thresh` greater than `DEPTH` means `data_avail` never sets; a `data_thresh` of 0 means it is always set.
- **Error flags:**
  - `overflow` sets on `fifo_push & fifo_full`; `underflow` sets on `fifo_pop & fifo_empty`.
  - Both hold until `err_clr`, `reset_fifo`, or `sys_rstn`.
  - If a set and `err_clr` occur in the same cycle, the set wins.
- **`reset_fifo`:**
  - Clears the pointers, count, error flags, and `fifo_out` (standard mode) to 0.
  - A push or pop in that same cycle is ignored.
  - `data_avail` and `almost_full` recompute on the next edge.
- **`sys_rstn` low:** all registers go to 0 immediately, including `fifo_out`, `data_avail`, `almost_full`, and the error flags. Consequently `fifo_empty` is 1 and `fifo_full` is 0. Reset mid-transfer discards all contents.

## Timing
- **Push to count:** a push at edge N is reflected in `fifo_count`, `fifo_empty`, and `fifo_full` after edge N.
- **Threshold flags:** `data_avail` and `almost_full` update after edge N+1.
- **Standard mode read latency:** a pop at edge N presents the popped word on `fifo_out` after edge N.
- **Throughput:** one push and one pop per cycle, sustained.

## Configuration
- Macro `SYNC_FIFO_PARAM_FWFT_EN`.
- **Defined (first-word fall-through):**
  - `fifo_out` is the asynchronous RAM read `mem[rd_ptr]` and always shows the oldest word whenever `fifo_empty` = 0.
  - A push into an empty FIFO at edge N is visible on `fifo_out` after edge N.
  - A pop at edge N consumes the current word, and the next word is shown after edge N.
  - While the FIFO is empty, `fifo_out` is don't-care.
- **Undefined:** standard registered read mode as described under Operation.

## Test plan
All scenarios use `DWIDTH`=8, `DEPTH`=4.
- **Reset:** assert `sys_rstn`=0 mid-stream. Expect `fifo_count`=0, `fifo_empty`=1, `fifo_out`=0x00, and all flags 0 with no clock edge required.
- **Fill:** push 0x11, 0x22, 0x33, 0x44.
  - Expect `fifo_full`=1 and `fifo_count`=4.
  - A 5th push of 0x55 leaves `fifo_count`=4 and sets `overflow`=1.
  - Popping 4 times returns 0x11..0x44 in order; the 44 must not be overwritten.
- **Wrap-around:** run 10 interleaved push/pop pairs of incrementing data. Expect the output sequence to match exactly and `fifo_count` never to exceed 1.
- **Empty boundary:**
  - Pop while empty: expect `underflow`=1 and the count stays at 0.
  - Simultaneous push 0xA5 and pop while empty: expect `fifo_count`=1, then the next pop returns 0xA5.
  - Simultaneous push 0x66 and pop while full: expect the count to go 4→3, `overflow`=1, and 0x66 never to appear on `fifo_out`.
- **Thresholds:** with `data_thresh`=2 and `space_thresh`=1, push 3 words.
  - `data_avail` rises one cycle after the count reaches 2.
  - `almost_full` rises one cycle after the count reaches 3.
  - A simultaneous `err_clr` and a new overflow leaves `overflow`=1.
- **FWFT (macro defined):** push 0x7E into an empty FIFO. Expect `fifo_out`=0x7E after the same edge with no pop required.
